sample_requester: RTL
=====================

// Module: sample_requester
// PURPOSE
//  Requesting end of the generate_next/sample_ready sample interface. On each codec frame tick it
//  issues a one-cycle generate_next to a sample source (sine reader / note voice), waits for
//  sample_ready, captures the sample and presents it to the codec path with a valid pulse.
//  Detects missed frames and an unresponsive source. Sits between codec frame timing and voices.
// PARAMETERS
//  SAMPLE_WIDTH  16  width of sample_in / sample_out (two's complement)
//  TIMEOUT       8   max WAIT cycles for sample_ready before giving up; legal range 2..255
//  CNT_WIDTH     16  width of delivered-sample counter (wraps)
// PORTS
//  clk           in   1             single clock, all logic rising-edge
//  reset         in   1             synchronous, active-high
//  play_enable   in   1             1 = fetch from source; 0 = deliver silence
//  new_frame     in   1             one-cycle pulse per codec frame
//  sample_ready  in   1             source response, one-cycle pulse
//  sample_in     in   SAMPLE_WIDTH  source sample, valid when sample_ready=1
//  generate_next out  1             one-cycle request to source
//  sample_out    out  SAMPLE_WIDTH  registered sample to codec
//  sample_valid  out  1             one-cycle pulse: sample_out updated this cycle
//  busy          out  1             1 in REQ or WAIT
//  overrun       out  1             sticky: new_frame arrived while busy
//  timeout_err   out  1             sticky: source failed to answer within TIMEOUT
//  sample_count  out  CNT_WIDTH     number of sample_valid pulses, wraps to 0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (sample_out=0, stickies cleared, sample_count=0).
//  States: IDLE, REQ, WAIT (Moore outputs: generate_next=(state==REQ), busy=(state!=IDLE)).
//  IDLE: new_frame&play_enable -> REQ. new_frame&!play_enable -> stay IDLE, sample_out<=0,
//   sample_valid pulses next cycle. sample_ready in IDLE ignored (no capture, no flag).
//  REQ: lasts exactly one cycle -> WAIT; wait timer cleared to 0.
//  WAIT: sample_ready=1 -> sample_out<=sample_in, sample_valid next cycle, -> IDLE.
//   else timer+1; if timer==TIMEOUT-1 with no ready -> IDLE, timeout_err<=1, sample_out held,
//   sample_valid still pulses next cycle (codec repeats last sample).
//  Latency vs 2-cycle source: new_frame cycle 0 -> generate_next cycle 1 -> sample_ready
//   cycle 3 -> sample_out/sample_valid cycle 4.
//  new_frame while in REQ or WAIT: frame dropped (not queued), overrun<=1; in-flight request
//   continues unaffected (incl. same-cycle sample_ready in WAIT: capture proceeds).
//  play_enable falling while busy: in-flight request completes normally; affects next frame only.
//  Exactly one sample_valid per accepted frame; never two requests outstanding.
//  sample_count increments on every sample_valid cycle, wraps 2^CNT_WIDTH-1 -> 0.
//  Stickies clear only on reset. Reset mid-WAIT: IDLE next cycle, late sample_ready ignored.
//  sample_in captured verbatim; no sign/width conversion.
// STRUCTURE
//  Package: state encoding constants (IDLE/REQ/WAIT, 2 bits), SAMPLE_WIDTH default.
//  Sub-module: wait_timer (clear, enable, terminal-count flag at TIMEOUT-1).
//  State, sample_out, stickies, counter built from dffr/dffre register instances.
// TESTING
//  1 2-cycle source model, new_frame at cycle 0, sample_in=16'h1234 -> generate_next high
//    cycle 1 only; sample_out=16'h1234 and sample_valid high cycle 4; sample_count=1.
//  2 Source never answers, TIMEOUT=8 -> exit WAIT after 8 cycles; timeout_err=1; sample_out
//    keeps previous value 16'h1234; sample_valid one pulse.
//  3 Second new_frame 1 cycle after first -> one generate_next total, overrun=1, one valid.
//  4 play_enable=0, new_frame -> no generate_next; sample_out=0, sample_valid pulse next cycle.
//  5 Stray sample_ready=1 in IDLE with sample_in=16'hFFFF -> sample_out unchanged, no flags.
//  6 Reset asserted during WAIT -> all outputs 0 next cycle; following sample_ready ignored;
//    CNT_WIDTH=4, 16 frames -> sample_count wraps to 0.

Source files
------------

// File: rtl/sample_requester_pkg.sv
// Shared definitions for the sample requester: FSM state encoding and default widths.
package sample_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int TIMER_WIDTH      = 8;

endpackage

// File: rtl/dffr.sv
// D register with synchronous active-high reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/dffre.sv
// D register with load enable and synchronous active-high reset to zero.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with synchronous clear and hold when not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sample_requester_wait_timer.sv
// Counts cycles spent waiting for the sample source; flags the last allowed cycle.
module sample_requester_wait_timer
  import sample_requester_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TIMER_WIDTH-1:0] TC_VALUE = TIMER_WIDTH'(TIMEOUT - 1);

  logic [TIMER_WIDTH-1:0] count_r;

  // Wait-cycle counter
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= {TIMER_WIDTH{1'b0}};
    end else if (enable) begin
      count_r <= count_r + TIMER_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VALUE);

endmodule

// File: rtl/sample_requester.sv
// Requests one sample from a source per codec frame, captures it and presents it
// with a valid pulse; flags dropped frames and an unresponsive source.
module sample_requester
  import sample_requester_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int TIMEOUT      = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play_enable,
  input  logic                    new_frame,
  input  logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    generate_next,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic [CNT_WIDTH-1:0]    sample_count
);

  logic [1:0]              state_q_s;
  state_e                  state_r;
  state_e                  state_nxt_s;
  logic                    timer_clr_s;
  logic                    timer_en_s;
  logic                    timer_tc_s;
  logic                    load_s;
  logic [SAMPLE_WIDTH-1:0] load_val_s;
  logic                    valid_nxt_s;
  logic                    ovr_set_s;
  logic                    to_set_s;
  logic                    gen_nxt_s;
  logic                    busy_nxt_s;
  logic                    overrun_nxt_s;
  logic                    timeout_nxt_s;
  logic [CNT_WIDTH-1:0]    count_inc_s;

  assign state_r = state_e'(state_q_s);

  // Next-state and datapath control; frames arriving while busy are dropped, never queued
  always_comb begin
    state_nxt_s = state_r;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    load_s      = 1'b0;
    load_val_s  = {SAMPLE_WIDTH{1'b0}};
    valid_nxt_s = 1'b0;
    ovr_set_s   = 1'b0;
    to_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        if (new_frame && play_enable) begin
          state_nxt_s = ST_REQ;
        end else if (new_frame) begin
          load_s      = 1'b1;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_nxt_s = ST_WAIT;
        timer_clr_s = 1'b1;
        ovr_set_s   = new_frame;
      end
      ST_WAIT: begin
        ovr_set_s = new_frame;
        if (sample_ready) begin
          state_nxt_s = ST_IDLE;
          load_s      = 1'b1;
          load_val_s  = sample_in;
          valid_nxt_s = 1'b1;
        end else if (timer_tc_s) begin
          // Give up but still pulse valid so the codec repeats the held sample
          state_nxt_s = ST_IDLE;
          to_set_s    = 1'b1;
          valid_nxt_s = 1'b1;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign gen_nxt_s     = (state_nxt_s == ST_REQ);
  assign busy_nxt_s    = (state_nxt_s != ST_IDLE);
  assign overrun_nxt_s = overrun | ovr_set_s;
  assign timeout_nxt_s = timeout_err | to_set_s;
  assign count_inc_s   = sample_count + CNT_WIDTH'(1);

  sample_requester_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr_s),
    .enable (timer_en_s),
    .tc     (timer_tc_s)
  );

  dffr #(.W(2)) u_state (
    .clk(clk), .reset(reset), .d(state_nxt_s), .q(state_q_s)
  );

  // Request and busy are registered from the next state so they track the state exactly
  dffr #(.W(1)) u_gen (
    .clk(clk), .reset(reset), .d(gen_nxt_s), .q(generate_next)
  );

  dffr #(.W(1)) u_busy (
    .clk(clk), .reset(reset), .d(busy_nxt_s), .q(busy)
  );

  dffre #(.W(SAMPLE_WIDTH)) u_sample (
    .clk(clk), .reset(reset), .en(load_s), .d(load_val_s), .q(sample_out)
  );

  dffr #(.W(1)) u_valid (
    .clk(clk), .reset(reset), .d(valid_nxt_s), .q(sample_valid)
  );

  dffr #(.W(1)) u_overrun (
    .clk(clk), .reset(reset), .d(overrun_nxt_s), .q(overrun)
  );

  dffr #(.W(1)) u_timeout (
    .clk(clk), .reset(reset), .d(timeout_nxt_s), .q(timeout_err)
  );

  dffre #(.W(CNT_WIDTH)) u_count (
    .clk(clk), .reset(reset), .en(valid_nxt_s), .d(count_inc_s), .q(sample_count)
  );

endmodule
